mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port and shares it between two requesters: instruction fetch (IF) and the MEM-stage load/store.
- Assembles and splits 32-bit words into byte transfers, one byte per cycle.
- Reports completion to each requester with a one-cycle done pulse; stages stall on their own pending request until done.
- Sits between the IF/MEM stages and the top-level RAM interface.

Parameters:
- ADDR_W, 32, width of all address ports.
- IO_ADDR_BIT, 17, address bit that selects the IO region (used only by the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset: state is reset on a rising clk edge where rst==0.
- rdy  in  1  global enable; 0 freezes all state.
- jump_flush  in  1  abort any in-flight IF fetch.
- if_req  in  1  IF read request, level, held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle pulse; if_inst valid this cycle.
- if_inst  out  32  fetched instruction.
- mem_req  in  1  MEM request, level, held until mem_done.
- mem_wr  in  1  0=Read, 1=Write.
- mem_addr  in  ADDR_W  load/store address.
- mem_type  in  2  00 byte, 01 half, 10 word (11 treated as word).
- mem_wdata  in  32  store data; low bytes used.
- mem_done  out  1  one-cycle pulse; mem_rdata valid this cycle for reads.
- mem_rdata  out  32  load data, zero-padded, no sign extension (MEM stage extends per funct3).
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write strobe.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte, valid the cycle after its address is driven.

Behaviour:
- Reset values: state IDLE; if_done, mem_done, ram_wr = 0; if_inst, mem_rdata, ram_addr, ram_dout = 0; byte counter = 0.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE accept:
  - mem_req=1 → MEM_RD or MEM_WR. MEM wins over IF: it is the older instruction.
  - else if_req=1 and jump_flush=0 → IF_RD.
  - Base address and N latched at accept: IF N=4; MEM N=1, 2 or 4 per mem_type.
- Read states (counter c = 0..N):
  - ram_addr = base+c for c<N; held at base+N-1 for c=N.
  - At the edge ending cycle c≥1, ram_din → byte c-1, stored little-endian at bits [8(c-1)+7 : 8(c-1)].
  - After the edge ending c=N, go to DONE.
- Write state (c = 0..N-1):
  - ram_wr=1, ram_addr=base+c, ram_dout=wdata byte c.
  - After c=N-1, go to DONE.
  - ram_wr=0 in every other state.
- DONE lasts exactly one cycle:
  - Assert the matching done pulse with data; next state IDLE.
  - No accept occurs in DONE, so a held req is never double-accepted. Earliest new accept is the cycle after done.
- Latency from the accept edge to the done cycle:
  - word read: 6 cycles; byte read: 3 cycles.
  - word write: 5 cycles; byte write: 2 cycles.
- Unused upper bytes of mem_rdata = 0. if_inst and mem_rdata hold their value after done.
- jump_flush:
  - In IF_RD: abort; next state IDLE; no if_done; counter cleared.
  - In IDLE: blocks IF accept that cycle.
  - Ignored in MEM states and in DONE with a MEM transfer. If DONE carries an IF result while jump_flush=1, if_done is suppressed.
- rdy=0:
  - State, counter and captured bytes frozen; ram_wr forced 0.
  - ram_addr re-drives the last issued byte address, so ram_din is valid on the resume cycle.
  - Done pulses extend while frozen.
- rst=0 mid-transfer: abort at that edge, all outputs return to reset values, no done pulse.
- Request inputs are sampled only in IDLE; changes during a transfer are ignored.

Optional Feature:
- Macro: IO_BUFFER_STALL_EN.
- Defined:
  - Adds input io_buffer_full (1 bit).
  - In MEM_WR, when base[IO_ADDR_BIT]=1 and io_buffer_full=1: ram_wr=0 and the counter holds. Resume when io_buffer_full=0.
  - MEM_WR then exits to IDLE for two extra cycles before any new accept, covering the buffer-full flag's one-cycle lag.
- Undefined: port absent; IO writes proceed like RAM writes.

Test Plan:
- if_req=1, if_addr=0x100, RAM[0x100..0x103]=13 05 10 00 → ram_addr 0x100..0x103 issued; if_done exactly one cycle, 6 cycles after accept; if_inst=0x00100513.
- Same cycle mem_req=1 (Read, type 10, addr 0x200, RAM=EF BE AD DE) and if_req=1 → MEM served first; mem_rdata=0xDEADBEEF; IF accepted the cycle after mem_done.
- mem_req Write, type 01, addr 0x300, wdata=0x1234ABCD → ram_wr 2 cycles: (0x300,CD), (0x301,AB); mem_done next cycle; ram_wr never high outside those cycles.
- IF_RD word fetch with jump_flush=1 at c=2 → back to IDLE next edge; no if_done; a new if_req accepted the following cycle.
- rdy=0 for 3 cycles at c=2 of a word read → no byte lost or duplicated; data matches RAM. Separately, rst=0 mid-write → ram_wr=0 and all outputs 0 after that edge.
- With IO_BUFFER_STALL_EN: byte write to 0x30000 with io_buffer_full=1 for 4 cycles → ram_wr=0 during those cycles, write occurs once flag drops, mem_done follows.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between instruction fetch and
// the MEM-stage load/store. 32-bit words are moved one byte per cycle,
// little-endian. Each finished transfer gives its requester a one-cycle
// done pulse.
// Optional feature, enabled by defining IO_BUFFER_STALL_EN: writes to the
// IO region stall while io_buffer_full is high.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int IO_ADDR_BIT = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_type,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
`ifdef IO_BUFFER_STALL_EN
  ,
  input  logic              io_buffer_full
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_IF_RD  = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_MEM_WR = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              is_if_q, is_if_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [1:0]        gap_q, gap_d;

  logic              io_full;
  logic              wr_stall;
  logic [2:0]        offs;
  logic [1:0]        bidx;

`ifdef IO_BUFFER_STALL_EN
  localparam bit GAP_EN = 1'b1;
  assign io_full = io_buffer_full;
`else
  localparam bit GAP_EN = 1'b0;
  assign io_full = 1'b0;
`endif

  // IO-region write blocked while the downstream buffer reports full
  assign wr_stall = base_q[IO_ADDR_BIT] & io_full;

  assign if_done   = (state_q == S_DONE) && is_if_q && !jump_flush;
  assign mem_done  = (state_q == S_DONE) && !is_if_q;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;

  // RAM port drive; when frozen, re-present the last issued address so
  // ram_din is valid on the resume cycle
  always_comb begin
    offs     = (cnt_q == n_q) ? cnt_q - 3'd1 : cnt_q;
    ram_addr = last_addr_q;
    ram_wr   = 1'b0;
    ram_dout = 8'h00;
    if (rdy) begin
      case (state_q)
        S_IF_RD, S_MEM_RD: ram_addr = base_q + ADDR_W'(offs);
        S_MEM_WR: begin
          ram_addr = base_q + ADDR_W'(cnt_q);
          ram_wr   = !wr_stall;
          ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end
        default: ;
      endcase
    end
  end

  // Transfer sequencing: accept in IDLE, step one byte per enabled cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    is_if_d     = is_if_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    gap_d       = gap_q;
    last_addr_d = ram_addr;
    bidx        = cnt_q[1:0] - 2'd1;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (gap_q != 2'd0) begin
            gap_d = gap_q - 2'd1;
          end else if (mem_req) begin
            // MEM holds the older instruction, so it wins
            state_d = mem_wr ? S_MEM_WR : S_MEM_RD;
            is_if_d = 1'b0;
            base_d  = mem_addr;
            n_d     = (mem_type == 2'b00) ? 3'd1 : (mem_type == 2'b01) ? 3'd2 : 3'd4;
            wdata_d = mem_wdata;
            cnt_d   = 3'd0;
            buf_d   = 32'h0;
          end else if (if_req && !jump_flush) begin
            state_d = S_IF_RD;
            is_if_d = 1'b1;
            base_d  = if_addr;
            n_d     = 3'd4;
            cnt_d   = 3'd0;
            buf_d   = 32'h0;
          end
        end
        S_IF_RD, S_MEM_RD: begin
          if (state_q == S_IF_RD && jump_flush) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
          end else begin
            // ram_din carries the byte addressed in the previous cycle
            if (cnt_q != 3'd0) buf_d[{bidx, 3'b000} +: 8] = ram_din;
            if (cnt_q == n_q) begin
              state_d = S_DONE;
              cnt_d   = 3'd0;
              if (is_if_q) if_inst_d = buf_d;
              else         mem_rdata_d = buf_d;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_MEM_WR: begin
          if (!wr_stall) begin
            if (cnt_q == n_q - 3'd1) begin
              state_d = S_DONE;
              cnt_d   = 3'd0;
              // the buffer-full flag lags a cycle; keep IDLE quiet a bit
              if (GAP_EN && base_q[IO_ADDR_BIT]) gap_d = 2'd2;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      is_if_q     <= 1'b0;
      base_q      <= '0;
      last_addr_q <= '0;
      wdata_q     <= 32'h0;
      buf_q       <= 32'h0;
      if_inst_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      gap_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      is_if_q     <= is_if_d;
      base_q      <= base_d;
      last_addr_q <= last_addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      gap_q       <= gap_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random transactions against a byte RAM model
// and a shadow memory holding the expected contents.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy, jump_flush;
  logic        if_req, mem_req, mem_wr;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_type;
  logic        if_done, mem_done, ram_wr;
  logic [31:0] if_inst, mem_rdata, ram_addr;
  logic [7:0]  ram_dout, ram_din;
`ifdef IO_BUFFER_STALL_EN
  logic        io_full;
`endif

  int nerr = 0;
  int nchk = 0;
  int unsigned seed;
  logic [31:0] addr_log [0:31];
  logic [7:0]  shadow [0:4095];
  logic [7:0]  wram [0:4095];
  bit          written [0:4095];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_flush(jump_flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_type(mem_type),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
`ifdef IO_BUFFER_STALL_EN
    , .io_buffer_full(io_full)
`endif
  );

  function automatic logic [7:0] init_byte(input logic [11:0] a);
    logic [31:0] h;
    case (a)
      12'h100: return 8'h13;
      12'h101: return 8'h05;
      12'h102: return 8'h10;
      12'h103: return 8'h00;
      12'h200: return 8'hEF;
      12'h201: return 8'hBE;
      12'h202: return 8'hAD;
      12'h203: return 8'hDE;
      default: begin
        h = ({20'h0, a} * 32'h9E3779B1) ^ seed;
        return h[20:13];
      end
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [11:0] a);
    return written[a] ? wram[a] : init_byte(a);
  endfunction

  // byte RAM: read data appears the cycle after the address
  always @(posedge clk) begin
    ram_din <= ram_rd(ram_addr[11:0]);
    if (ram_wr) begin
      wram[ram_addr[11:0]]    <= ram_dout;
      written[ram_addr[11:0]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request from reset-idle to done; expectations come from the shadow
  // memory and the latency rule (reads N+2 cycles, writes N+1 cycles).
  task automatic run_txn(input bit is_if, input bit wr, input logic [31:0] addr,
                         input logic [1:0] typ, input logic [31:0] wd, input string tag);
    int n, lat, exp_lat, kw;
    bit is_wr;
    logic [31:0] exp_d, got_d;
    is_wr = wr && !is_if;
    n = is_if ? 4 : (typ == 2'd0 ? 1 : (typ == 2'd1 ? 2 : 4));
    exp_lat = is_wr ? n + 1 : n + 2;
    exp_d = 32'h0;
    if (!is_wr) for (int i = 0; i < n; i++) exp_d[8*i +: 8] = shadow[12'(addr + 32'(i))];
    @(negedge clk);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_wr = wr; mem_addr = addr; mem_type = typ; mem_wdata = wd;
    end
    lat = 0; kw = 0; got_d = 32'h0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk); #1;
      addr_log[k] = ram_addr;
      if (ram_wr) begin
        if (kw < n) begin
          chk({tag, "_waddr"}, ram_addr, addr + 32'(kw));
          chk({tag, "_wbyte"}, {24'h0, ram_dout}, {24'h0, wd[8*kw +: 8]});
        end
        kw++;
      end
      if (is_if ? if_done : mem_done) begin
        lat = k;
        got_d = is_if ? if_inst : mem_rdata;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (is_wr) begin
      chk({tag, "_nwr"}, 32'(kw), 32'(n));
      for (int i = 0; i < n; i++) shadow[12'(addr + 32'(i))] = wd[8*i +: 8];
    end else begin
      chk({tag, "_nwr"}, 32'(kw), 32'd0);
      chk({tag, "_data"}, got_d, exp_d);
    end
    @(negedge clk); #1;
    chk({tag, "_pulse"}, {31'h0, is_if ? if_done : mem_done}, 32'h0);
  endtask

  initial begin
    int md, id, dk, wk, wcnt, mism;
    bit r_if, r_wr;
    logic [31:0] saved;
    seed = $urandom;
    for (int i = 0; i < 4096; i++) shadow[i] = init_byte(12'(i));
    rst = 1'b0; rdy = 1'b1; jump_flush = 1'b0;
    if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_wr = 1'b0;
    mem_addr = 32'h0; mem_type = 2'd0; mem_wdata = 32'h0;
`ifdef IO_BUFFER_STALL_EN
    io_full = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_if_done", {31'h0, if_done}, 32'h0);
    chk("rst_mem_done", {31'h0, mem_done}, 32'h0);
    chk("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
    rst = 1'b1;

    // plain instruction fetch
    run_txn(1'b1, 1'b0, 32'h100, 2'd2, 32'h0, "if100");
    for (int i = 1; i <= 4; i++) chk($sformatf("if100_addr%0d", i), addr_log[i], 32'h100 + 32'(i - 1));
    chk("if100_inst", if_inst, 32'h00100513);

    // simultaneous requests: MEM first, IF accepted right after mem_done
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h200; mem_type = 2'd2;
    if_req = 1'b1; if_addr = 32'h100;
    md = 0; id = 0; saved = 32'h0;
    for (int k = 1; k <= 30 && id == 0; k++) begin
      @(negedge clk); #1;
      if (mem_done && md == 0) begin md = k; saved = mem_rdata; mem_req = 1'b0; end
      if (if_done) id = k;
    end
    if_req = 1'b0;
    chk("both_mem_lat", 32'(md), 32'd6);
    chk("both_mem_data", saved, 32'hDEADBEEF);
    chk("both_if_lat", 32'(id), 32'd13);
    chk("both_if_inst", if_inst, 32'h00100513);
    @(negedge clk);

    // half-word store
    run_txn(1'b0, 1'b1, 32'h300, 2'd1, 32'h1234ABCD, "wr300");

    // fetch flushed at byte 2, then a new fetch the next cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    id = 0;
    for (int k = 1; k <= 30 && id == 0; k++) begin
      @(negedge clk);
      if (k == 3) jump_flush = 1'b1;
      if (k == 4) begin jump_flush = 1'b0; if_addr = 32'h200; end
      #1;
      if (if_done) id = k;
    end
    if_req = 1'b0;
    chk("flush_if_lat", 32'(id), 32'd10);
    chk("flush_if_inst", if_inst, 32'hDEADBEEF);
    @(negedge clk);

    // rdy low for three cycles in the middle of a word load
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h200; mem_type = 2'd3;
    md = 0;
    for (int k = 1; k <= 30 && md == 0; k++) begin
      @(negedge clk);
      if (k == 3) rdy = 1'b0;
      if (k == 6) rdy = 1'b1;
      #1;
      if (mem_done) md = k;
    end
    mem_req = 1'b0;
    chk("frz_lat", 32'(md), 32'd9);
    chk("frz_data", mem_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // reset during a word store
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h380; mem_type = 2'd2; mem_wdata = 32'h55667788;
    md = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 2) begin rst = 1'b0; mem_req = 1'b0; end
      #1;
      if (mem_done) md = k;
    end
    chk("rstw_nodone", 32'(md), 32'd0);
    chk("rstw_ram_wr", {31'h0, ram_wr}, 32'h0);
    chk("rstw_ram_addr", ram_addr, 32'h0);
    chk("rstw_ram_dout", {24'h0, ram_dout}, 32'h0);
    chk("rstw_if_inst", if_inst, 32'h0);
    chk("rstw_mem_rdata", mem_rdata, 32'h0);
    chk("rstw_mem_done", {31'h0, mem_done}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

`ifdef IO_BUFFER_STALL_EN
    // IO byte store held off while the buffer is full
    @(negedge clk);
    io_full = 1'b1;
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h30000; mem_type = 2'd0; mem_wdata = 32'h000000A5;
    dk = 0; wk = 0; wcnt = 0;
    for (int k = 1; k <= 15 && dk == 0; k++) begin
      @(negedge clk);
      if (k == 5) io_full = 1'b0;
      #1;
      if (ram_wr) begin
        wcnt++; wk = k;
        chk("io_waddr", ram_addr, 32'h30000);
        chk("io_wbyte", {24'h0, ram_dout}, 32'hA5);
      end
      if (mem_done) dk = k;
    end
    mem_req = 1'b0;
    shadow[12'h000] = 8'hA5;
    chk("io_nwr", 32'(wcnt), 32'd1);
    chk("io_wcycle", 32'(wk), 32'd5);
    chk("io_lat", 32'(dk), 32'd6);
    repeat (4) @(negedge clk);
`endif

    // random traffic against the shadow memory
    for (int t = 0; t < 40; t++) begin
      r_if = ($urandom_range(0, 2) == 0);
      r_wr = $urandom_range(0, 1) == 1;
      run_txn(r_if, r_wr, 32'h400 + 32'($urandom_range(0, 32'hB00)), 2'($urandom_range(0, 3)),
              $urandom, $sformatf("rnd%0d", t));
    end

    mism = 0;
    for (int a = 12'h400; a < 4096; a++) if (ram_rd(12'(a)) !== shadow[a]) mism++;
    chk("ram_contents", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
